alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Execute stage directly downstream of the register bank: consumes op1/op2 as
//  read from the bank, computes the selected operation and returns the result
//  with a write-back address/enable that drive the bank's Dir/Dato/WE inputs.
//  Single-cycle ops finish in 1 cycle. MUL/DIVU/REMU use a 32-step iterative
//  datapath with a start/busy/done handshake.
// PARAMETERS
//  WIDTH   32  operand/result width
//  ADDR_W  5   register address width; 32 registers
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  start     in   1        request; accepted only when busy=0
//  ALUOp     in   3        000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT(signed),
//                          101 MUL(low word, unsigned), 110 DIVU, 111 REMU
//  op1       in   WIDTH    operand A from register bank
//  op2       in   WIDTH    operand B from register bank
//  dir_in    in   ADDR_W   destination register of this operation
//  busy      out  1        operation in progress; new start ignored
//  done      out  1        1-cycle pulse, result valid
//  result    out  WIDTH    result, held until the next accepted start completes
//  wb_dir    out  ADDR_W   write-back address (to bank Dir)
//  wb_we     out  1        write-back enable (to bank WE), equals done
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; busy=0, done=0, wb_we=0, result=0,
//   wb_dir=0, iteration counter=0. Asserting rst mid-operation aborts it.
//   No done/wb_we is produced for the aborted op.
//  States: IDLE, ITER, DONE.
//  Acceptance: start=1 with busy=0 at edge k. ALUOp, op1, op2 and dir_in are
//   latched at edge k. Later input changes have no effect.
//   start while busy=1 is ignored (not queued).
//  ADD/SUB/AND/OR/SLT: result computed at edge k. IDLE->DONE.
//   done=wb_we=1 for the cycle after edge k. Latency 1. busy stays 0.
//  ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT gives 1 if
//   $signed(op1)<$signed(op2), else 0.
//  MUL/DIVU/REMU with op2!=0: IDLE->ITER at edge k. busy=1 from edge k.
//   Counter 0..31, one shift-add (MUL) or restoring step (DIV) per edge on
//   edges k+1..k+32. On edge k+32: result written, ITER->DONE, busy=0,
//   done=wb_we=1. Latency 32.
//  MUL: low WIDTH bits of the unsigned product; upper bits discarded.
//  DIVU/REMU, op2=0: no iteration, treated as single-cycle (latency 1).
//   DIVU gives all ones (32'hFFFFFFFF). REMU gives op1.
//  DONE lasts exactly 1 cycle and then returns to IDLE.
//   A start in the DONE cycle is accepted, because busy=0 then.
//   This allows back-to-back ops with no bubble.
//  wb_dir = latched dir_in, updated when result is written and held afterwards.
//   wb_we is never high outside the done cycle.
//  Writes to register 0 are not filtered here; the register bank owns that policy.
// TESTING
//  1 ADD op1=7, op2=5, dir_in=3 -> next cycle: result=12, done=wb_we=1, wb_dir=3;
//    following cycle done=0.
//  2 SUB 0-1 -> 32'hFFFFFFFF. SLT op1=-2, op2=1 -> 1. SLT op1=1, op2=-2 -> 0.
//  3 MUL 32'h0001_0003 x 32'h0002_0005 -> busy=1 for 32 cycles, then
//    result=32'h000B_000F, done pulse at edge k+32 exactly.
//  4 DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at k+32.
//    DIVU x/0 -> FFFFFFFF at k+1. REMU 9/0 -> 9 at k+1.
//  5 MUL started, then start pulsed with new operands at k+5 -> ignored;
//    the original product is returned at k+32.
//    A start in the done cycle -> accepted.
//  6 rst=1 at k+10 during DIVU -> busy/done/wb_we go 0 immediately and result=0.
//    No done pulse follows. A new ADD after rst release works normally.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_muldiv
// Description : Execute stage behind the register bank. ADD/SUB/AND/OR/SLT
//               complete in one cycle. MUL (low word, unsigned), DIVU and REMU
//               use a 32-step shift-add / restoring-divide datapath with a
//               start/busy/done handshake. Divide by zero is single-cycle.
// Ports       : clk, rst (async, active-high)
//               start, ALUOp[2:0], op1, op2, dir_in  - request and operands
//               busy                                  - iteration in progress
//               done / wb_we                          - 1-cycle result strobe
//               result, wb_dir                        - held write-back data
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_muldiv #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        ALUOp,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [ADDR_W-1:0] dir_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ADDR_W-1:0] wb_dir,
    output logic              wb_we
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_SLT  = 3'b100;
    localparam logic [2:0] c_OP_MUL  = 3'b101;
    localparam logic [2:0] c_OP_DIVU = 3'b110;
    localparam logic [2:0] c_OP_REMU = 3'b111;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [ADDR_W-1:0]  r_dir;
    logic [4:0]         r_cnt;
    // Shared iteration registers:
    //   MUL : r_acc = partial product, r_x = multiplicand (shifts left),
    //         r_y = multiplier (shifts right)
    //   DIV : r_acc = partial remainder, r_x = dividend shifting out / quotient
    //         shifting in, r_y = divisor
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;

    logic               w_accept;
    logic               w_is_iter_op;
    logic               w_go_iter;
    logic [WIDTH-1:0]   w_single;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_iter_result;

    assign w_accept     = start && !busy;
    assign w_is_iter_op = (ALUOp == c_OP_MUL) || (ALUOp == c_OP_DIVU) || (ALUOp == c_OP_REMU);
    // Divide by zero has a defined answer and skips iteration; MUL always iterates.
    assign w_go_iter    = w_is_iter_op && ((ALUOp == c_OP_MUL) || (op2 != '0));

    always_comb begin
        w_single = '0;
        case (ALUOp)
            c_OP_ADD:  w_single = op1 + op2;
            c_OP_SUB:  w_single = op1 - op2;
            c_OP_AND:  w_single = op1 & op2;
            c_OP_OR:   w_single = op1 | op2;
            c_OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            c_OP_DIVU: w_single = '1;
            c_OP_REMU: w_single = op1;
            default:   w_single = '0;
        endcase
    end

    // Shift-add step: the last step's sum is the final product.
    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);

    // Restoring-divide step: bring in the next dividend bit and subtract the
    // divisor if it fits (no borrow out of the extra top bit).
    assign w_rem_sh   = {r_acc, r_x[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_y};
    assign w_fits     = !w_diff[WIDTH];
    assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_next = {r_x[WIDTH-2:0], w_fits};

    always_comb begin
        w_iter_result = '0;
        case (r_op)
            c_OP_MUL:  w_iter_result = w_mul_acc;
            c_OP_DIVU: w_iter_result = w_quo_next;
            c_OP_REMU: w_iter_result = w_rem_next;
            default:   w_iter_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_dir   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            result  <= '0;
            wb_dir  <= '0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_op  <= ALUOp;
                        r_dir <= dir_in;
                        if (w_go_iter) begin
                            r_state <= ITER;
                            busy    <= 1'b1;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_x     <= op1;
                            r_y     <= op2;
                        end else begin
                            r_state <= DONE;
                            result  <= w_single;
                            wb_dir  <= dir_in;
                            done    <= 1'b1;
                            wb_we   <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (r_op == c_OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_x   <= {r_x[WIDTH-2:0], 1'b0};
                        r_y   <= {1'b0, r_y[WIDTH-1:1]};
                    end else begin
                        r_acc <= w_rem_next;
                        r_x   <= w_quo_next;
                    end
                    if (r_cnt == c_LAST_STEP) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        result  <= w_iter_result;
                        wb_dir  <= r_dir;
                        done    <= 1'b1;
                        wb_we   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_muldiv
// Description : Directed self-checking bench for alu_seq_muldiv. Inputs are
//               driven on the falling edge, outputs sampled on the falling
//               edge after each rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_muldiv;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] c_ADD  = 3'b000;
    localparam logic [2:0] c_SUB  = 3'b001;
    localparam logic [2:0] c_SLT  = 3'b100;
    localparam logic [2:0] c_MUL  = 3'b101;
    localparam logic [2:0] c_DIVU = 3'b110;
    localparam logic [2:0] c_REMU = 3'b111;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        ALUOp;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [ADDR_W-1:0] dir_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [ADDR_W-1:0] wb_dir;
    logic              wb_we;

    int errors = 0;
    int checks = 0;

    alu_seq_muldiv #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALUOp  (ALUOp),
        .op1    (op1),
        .op2    (op2),
        .dir_in (dir_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wb_dir (wb_dir),
        .wb_we  (wb_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one rising edge (edge k); returns at the falling
    // edge after edge k with start deasserted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d);
        @(negedge clk);
        start  = 1'b1;
        ALUOp  = op;
        op1    = a;
        op2    = b;
        dir_in = d;
        @(negedge clk);
        start  = 1'b0;
        op1    = 32'hDEAD_BEEF;
        op2    = 32'h0BAD_F00D;
        dir_in = 5'd31;
    endtask

    // From the sample point after edge k, wait through edges k+1..k+31 while
    // requiring busy=1/done=0, then step to edge k+32.
    task automatic wait_iter(input string tag, input int already);
        int bad;
        bad = 0;
        for (int i = already + 1; i <= 31; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0 || wb_we !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
        @(negedge clk);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; ALUOp = '0; op1 = '0; op2 = '0; dir_in = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   busy,   0);
        chk("reset_done",   done,   0);
        chk("reset_we",     wb_we,  0);
        chk("reset_result", result, 0);
        chk("reset_wbdir",  wb_dir, 0);
        rst = 1'b0;

        // 1: ADD 7+5 -> 12 at k+1, done for exactly one cycle
        issue(c_ADD, 32'd7, 32'd5, 5'd3);
        chk("add_result", result, 32'd12);
        chk("add_done",   done,   1);
        chk("add_we",     wb_we,  1);
        chk("add_wbdir",  wb_dir, 3);
        chk("add_busy",   busy,   0);
        @(negedge clk);
        chk("add_done_drop", done,   0);
        chk("add_we_drop",   wb_we,  0);
        chk("add_hold",      result, 32'd12);

        // 2: SUB wrap and signed SLT
        issue(c_SUB, 32'd0, 32'd1, 5'd4);
        chk("sub_result", result, 32'hFFFF_FFFF);
        chk("sub_wbdir",  wb_dir, 4);
        issue(c_SLT, 32'hFFFF_FFFE, 32'd1, 5'd5);
        chk("slt_neg_lt", result, 32'd1);
        issue(c_SLT, 32'd1, 32'hFFFF_FFFE, 5'd6);
        chk("slt_pos_ge", result, 32'd0);

        // 3: MUL low word, done exactly at k+32
        issue(c_MUL, 32'h0001_0003, 32'h0002_0005, 5'd7);
        chk("mul_busy_k", busy, 1);
        wait_iter("mul_busy_window", 0);
        chk("mul_done",   done,   1);
        chk("mul_we",     wb_we,  1);
        chk("mul_busy0",  busy,   0);
        chk("mul_result", result, 32'h000B_000F);
        chk("mul_wbdir",  wb_dir, 7);

        // 4: DIVU / REMU iterative and divide by zero
        issue(c_DIVU, 32'd100, 32'd7, 5'd8);
        wait_iter("divu_busy_window", 0);
        chk("divu_done",   done,   1);
        chk("divu_result", result, 32'd14);
        issue(c_REMU, 32'd100, 32'd7, 5'd9);
        wait_iter("remu_busy_window", 0);
        chk("remu_done",   done,   1);
        chk("remu_result", result, 32'd2);
        issue(c_DIVU, 32'h0000_1234, 32'd0, 5'd10);
        chk("divu0_done",   done,   1);
        chk("divu0_busy",   busy,   0);
        chk("divu0_result", result, 32'hFFFF_FFFF);
        issue(c_REMU, 32'd9, 32'd0, 5'd11);
        chk("remu0_done",   done,   1);
        chk("remu0_result", result, 32'd9);
        chk("remu0_wbdir",  wb_dir, 11);

        // 5: start while busy is ignored; start in the done cycle is accepted
        issue(c_MUL, 32'h0001_0003, 32'h0002_0005, 5'd12);
        repeat (4) @(negedge clk);
        start = 1'b1; ALUOp = c_ADD; op1 = 32'd1; op2 = 32'd1; dir_in = 5'd13;
        @(negedge clk);
        start = 1'b0;
        wait_iter("mul2_busy_window", 5);
        chk("mul2_done",   done,   1);
        chk("mul2_result", result, 32'h000B_000F);
        chk("mul2_wbdir",  wb_dir, 12);
        start = 1'b1; ALUOp = c_ADD; op1 = 32'd2; op2 = 32'd3; dir_in = 5'd14;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done",   done,   1);
        chk("b2b_result", result, 32'd5);
        chk("b2b_wbdir",  wb_dir, 14);

        // 6: async reset mid-DIVU aborts with no done afterwards
        issue(c_DIVU, 32'd100, 32'd7, 5'd15);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_we",     wb_we,  0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || wb_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_no_done", bad, 0);
        issue(c_ADD, 32'd20, 32'd22, 5'd1);
        chk("post_rst_done",   done,   1);
        chk("post_rst_result", result, 32'd42);
        chk("post_rst_wbdir",  wb_dir, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
